// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file arbiter slice.
// Holds the default sizes and the arbitration pointer width.
package rf_arb_pkg;

    localparam int NREQ_DEF       = 2;
    localparam int SEL_DEF        = 2;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int PTR_W          = $clog2(NREQ_DEF);

    // Keeps the pointer at least one bit wide when there is a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic for the shared register file.
// Round-robin by default; define RF_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

`ifdef RF_ARB_FIXED_PRIO_EN

    logic unused_clk;
    assign unused_clk = clk;

    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end
    end

`else

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            idx;

    // Search starts at ptr and wraps; the winner's successor becomes the new ptr.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_nxt  = PW'((idx + 1) % NREQ);
                found    = 1'b1;
            end
        end
        if (!rst_n) begin
            gnt     = '0;
            ptr_nxt = ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

`endif

endmodule

// File: rtl/reg_file_arbiter.sv
// Register file shared by NREQ requesters, one access per cycle.
// Arbitration policy follows RF_ARB_FIXED_PRIO_EN inside rr_arbiter.
module reg_file_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int SEL        = SEL_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ*SEL-1:0]        addr,
    input  logic [NREQ*DATA_WIDTH-1:0] wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** SEL;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc;
    logic                  acc_we;
    logic [SEL-1:0]        acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    // gnt is one-hot, so at most one requester's fields are steered through.
    always_comb begin
        acc       = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                acc       = 1'b1;
                acc_we    = we[i];
                acc_addr  = addr[i*SEL +: SEL];
                acc_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rvalid <= (acc && !acc_we) ? gnt : '0;
            if (acc && !acc_we) begin
                rdata <= mem[acc_addr];
            end
            if (acc && acc_we) begin
                mem[acc_addr] <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: scoreboarded 2-requester instance plus a 3-requester wrap check.
// Expectations follow RF_ARB_FIXED_PRIO_EN when it is defined.
module tb_reg_file_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;

    logic [2:0]  req3 = '0;
    logic [2:0]  we3 = '0;
    logic [5:0]  addr3 = '0;
    logic [47:0] wdata3 = '0;
    logic [2:0]  gnt3;
    logic [2:0]  rvalid3;
    logic [15:0] rdata3;

    always #5 clk = ~clk;

    reg_file_arbiter #(.NREQ(2), .SEL(2), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
    );

    reg_file_arbiter #(.NREQ(3), .SEL(2), .DATA_WIDTH(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3),
        .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [4];
    int          model_ptr;
    logic [15:0] model_rdata;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] modelGnt(input logic [1:0] r, input int p);
        logic [1:0] one;
        one = 2'b01;
`ifdef RF_ARB_FIXED_PRIO_EN
        if (r[0]) return 2'b01;
        if (r[1]) return 2'b10;
        return 2'b00;
`else
        for (int k = 0; k < 2; k++) begin
            if (r[(p + k) % 2]) return one << ((p + k) % 2);
        end
        return 2'b00;
`endif
    endfunction

    // One cycle: drive, check gnt, update the model, then check the registered response.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [1:0] a0, input logic [1:0] a1,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input string tag, output logic [1:0] seen);
        logic [1:0] eg;
        exp_t       e;
        exp_t       got;
        int         i;
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #3;
        seen = gnt;
        eg   = modelGnt(r, model_ptr);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eg));
        e.v = 2'b00;
        e.d = model_rdata;
        if (eg != 2'b00) begin
            i         = eg[1] ? 1 : 0;
            model_ptr = (i + 1) % 2;
            if (w[i]) begin
                model_mem[i ? a1 : a0] = i ? d1 : d0;
            end else begin
                e.v         = eg;
                e.d         = model_mem[i ? a1 : a0];
                model_rdata = e.d;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            checkOutput({tag, ".rvalid"}, 32'(rvalid), 32'(got.v));
            checkOutput({tag, ".rdata"}, 32'(rdata), 32'(got.d));
        end
    endtask

    task automatic resetDut(input string tag);
        req   = 2'b11;
        we    = 2'b00;
        addr  = '0;
        req3  = 3'b111;
        rst_n = 1'b0;
        #2;
        checkOutput({tag, ".rst_rvalid"}, 32'(rvalid), 32'd0);
        checkOutput({tag, ".rst_rdata"}, 32'(rdata), 32'd0);
        checkOutput({tag, ".rst_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, ".rst_gnt3"}, 32'(gnt3), 32'd0);
        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        model_ptr   = 0;
        model_rdata = '0;
        sb.delete();
        @(posedge clk);
        #1;
        req   = 2'b00;
        req3  = 3'b000;
        rst_n = 1'b1;
        #1;
        checkOutput({tag, ".post_rvalid"}, 32'(rvalid), 32'd0);
    endtask

    logic [1:0] seen;
    logic [1:0] contend_exp [4];
    logic [2:0] wrap_exp [6];

    initial begin
`ifdef RF_ARB_FIXED_PRIO_EN
        contend_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
        wrap_exp    = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        contend_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        wrap_exp    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        #1;
        resetDut("por");

        applyStimulus(2'b01, 2'b00, 2'd3, 2'd0, 16'h0, 16'h0, "rd_a3", seen);
        applyStimulus(2'b10, 2'b10, 2'd0, 2'd2, 16'h0, 16'hBEEF, "wr_beef", seen);
        applyStimulus(2'b01, 2'b00, 2'd2, 2'd0, 16'h0, 16'h0, "raw", seen);
        checkOutput("raw_const", 32'(rdata), 32'h0000BEEF);
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0, "idle_hold", seen);

        resetDut("contend");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b11, 2'b00, 2'd1, 2'd0, 16'h0, 16'h0, "contend", seen);
            checkOutput("contend_seq", 32'(seen), 32'(contend_exp[c]));
        end

        applyStimulus(2'b11, 2'b10, 2'd0, 2'd1, 16'h0, 16'h1234, "withdraw_a", seen);
        applyStimulus(2'b00, 2'b00, 2'd0, 2'd1, 16'h0, 16'h1234, "withdraw_b", seen);
        applyStimulus(2'b01, 2'b00, 2'd1, 2'd0, 16'h0, 16'h0, "withdraw_rd", seen);
        checkOutput("withdraw_nowrite", 32'(rdata), 32'd0);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                          16'($urandom), 16'($urandom), "rand", seen);
        end

        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'b01, 2'b01, 2'(a), 2'd0, 16'hA5A0 + 16'(a), 16'h0, "fill", seen);
        end
        applyStimulus(2'b10, 2'b00, 2'd0, 2'd3, 16'h0, 16'h0, "pre_rst_rd", seen);
        resetDut("mid");
        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'b10, 2'b00, 2'd0, 2'(a), 16'h0, 16'h0, "cleared", seen);
            checkOutput("cleared_const", 32'(rdata), 32'd0);
        end

        resetDut("wrap");
        for (int c = 0; c < 6; c++) begin
            req3 = 3'b111;
            #3;
            checkOutput("wrap3", 32'(gnt3), 32'(wrap_exp[c]));
            @(posedge clk);
            #1;
        end
        req3 = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
